fetch_ctrl: RTL and testbench

FETCH_CTRL -- requirements
Module: fetch_ctrl

---
 rtl/fetch_ctrl.sv | 155 +++++++++++++++
 tb/tb_fetch_ctrl.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: instruction fetch controller.
//
// Issues one instruction memory request at a time at the current PC, waits for
// its response, and hands the fetched word to decode. Branch and trap redirects
// steer the program counter, flush younger stages, and kill any in-flight fetch.
//
// Optional feature: define FETCH_CTRL_TRAP_EN to make the trap redirect ports
// functional. Trap takes priority over branch. Without the macro the trap ports
// stay on the module but are ignored.
//
// Parameters:
//   RESET_HOLD    cycles spent idle after reset release before the first fetch (>= 1)
//
// Ports:
//   clk_i          clock, rising edge
//   rst_ni         asynchronous active-low reset
//   pc_i           current PC from the program counter
//   dec_stall_i    decode cannot accept an instruction this cycle
//   br_req_i       branch/jump redirect strobe
//   br_pc_i        branch/jump target
//   trap_req_i     trap redirect strobe (FETCH_CTRL_TRAP_EN only)
//   trap_pc_i      trap target (FETCH_CTRL_TRAP_EN only)
//   imem_req_o     instruction memory request
//   imem_addr_o    instruction memory address
//   imem_gnt_i     request accepted by memory
//   imem_rvalid_i  read data valid
//   next_pc_o      next PC presented to the program counter
//   pc_stall_o     hold the program counter
//   fetch_valid_o  fetched word valid to decode
//   flush_o        kill younger pipeline stages
module fetch_ctrl #(
  parameter int unsigned RESET_HOLD = 4
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [31:0] pc_i,
  input  logic        dec_stall_i,
  input  logic        br_req_i,
  input  logic [31:0] br_pc_i,
  input  logic        trap_req_i,
  input  logic [31:0] trap_pc_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  output logic [31:0] next_pc_o,
  output logic        pc_stall_o,
  output logic        fetch_valid_o,
  output logic        flush_o
);

  localparam int unsigned    CNT_W     = (RESET_HOLD > 1) ? $clog2(RESET_HOLD) : 1;
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(RESET_HOLD - 1);

  typedef enum logic [1:0] {
    HOLD = 2'd0,
    REQ  = 2'd1,
    RSP  = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_next;
  // Set when the outstanding fetch belongs to a path that has been redirected
  // away from; its response must be dropped.
  logic             r_kill;
  logic             w_kill_next;

  logic             w_redir;
  logic [31:0]      w_redir_tgt;
  logic             w_unused;

  // Redirect targets are word aligned: low two bits are dropped.
`ifdef FETCH_CTRL_TRAP_EN
  assign w_redir     = trap_req_i | br_req_i;
  assign w_redir_tgt = trap_req_i ? {trap_pc_i[31:2], 2'b00} : {br_pc_i[31:2], 2'b00};
  assign w_unused    = ^{trap_pc_i[1:0], br_pc_i[1:0]};
`else
  assign w_redir     = br_req_i;
  assign w_redir_tgt = {br_pc_i[31:2], 2'b00};
  assign w_unused    = ^{trap_req_i, trap_pc_i, br_pc_i[1:0]};
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= HOLD;
      r_cnt   <= '0;
      r_kill  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      r_kill  <= w_kill_next;
    end
  end

  always_comb begin
    w_state_next  = r_state;
    w_cnt_next    = r_cnt;
    w_kill_next   = r_kill;
    imem_req_o    = 1'b0;
    imem_addr_o   = 32'd0;
    next_pc_o     = 32'd0;
    pc_stall_o    = 1'b1;
    fetch_valid_o = 1'b0;
    flush_o       = 1'b0;

    // A redirect outside HOLD always wins the PC for this cycle, even if
    // decode is stalled.
    if ((r_state != HOLD) && w_redir) begin
      next_pc_o  = w_redir_tgt;
      pc_stall_o = 1'b0;
      flush_o    = 1'b1;
    end

    case (r_state)
      HOLD: begin
        if (r_cnt == HOLD_LAST) begin
          w_state_next = REQ;
        end else begin
          w_cnt_next = r_cnt + CNT_W'(1);
        end
      end
      // Request depends only on state, so rvalid never reaches imem_req_o.
      REQ: begin
        imem_req_o  = 1'b1;
        imem_addr_o = pc_i;
        if (imem_gnt_i) begin
          w_state_next = RSP;
          if (w_redir) begin
            w_kill_next = 1'b1;
          end
        end
      end
      RSP: begin
        if (imem_rvalid_i) begin
          w_state_next = REQ;
          w_kill_next  = 1'b0;
          // Stalled decode: drop the word and re-fetch the same PC.
          if (!r_kill && !w_redir && !dec_stall_i) begin
            fetch_valid_o = 1'b1;
            pc_stall_o    = 1'b0;
            next_pc_o     = pc_i + 32'd4;
          end
        end else if (w_redir) begin
          w_kill_next = 1'b1;
        end
      end
      default: begin
        w_state_next = HOLD;
      end
    endcase
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed testbench for fetch_ctrl. Inputs change on the falling edge and
// outputs are sampled 1 time unit later, well away from the rising edge.
module tb_fetch_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic [31:0] pc_i = 32'd0;
  logic        dec_stall_i = 1'b0;
  logic        br_req_i = 1'b0;
  logic [31:0] br_pc_i = 32'd0;
  logic        trap_req_i = 1'b0;
  logic [31:0] trap_pc_i = 32'd0;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_gnt_i = 1'b0;
  logic        imem_rvalid_i = 1'b0;
  logic [31:0] next_pc_o;
  logic        pc_stall_o;
  logic        fetch_valid_o;
  logic        flush_o;

  int n_run  = 0;
  int n_fail = 0;

  always #5 clk_i = ~clk_i;

  fetch_ctrl #(.RESET_HOLD(4)) dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .pc_i          (pc_i),
    .dec_stall_i   (dec_stall_i),
    .br_req_i      (br_req_i),
    .br_pc_i       (br_pc_i),
    .trap_req_i    (trap_req_i),
    .trap_pc_i     (trap_pc_i),
    .imem_req_o    (imem_req_o),
    .imem_addr_o   (imem_addr_o),
    .imem_gnt_i    (imem_gnt_i),
    .imem_rvalid_i (imem_rvalid_i),
    .next_pc_o     (next_pc_o),
    .pc_stall_o    (pc_stall_o),
    .fetch_valid_o (fetch_valid_o),
    .flush_o       (flush_o)
  );

  task automatic set_idle();
    dec_stall_i   = 1'b0;
    br_req_i      = 1'b0;
    trap_req_i    = 1'b0;
    imem_gnt_i    = 1'b0;
    imem_rvalid_i = 1'b0;
  endtask

  // Reset, release, hold 4 cycles with pc_i=0 x; check reset values,
  // ignored redirects / responses in HOLD, and the first request in cycle 5.
  task automatic test_reset();
    @(negedge clk_i);
    rst_ni = 1'b0; set_idle(); pc_i = 32'd0;
    br_req_i = 1'b1; br_pc_i = 32'h0000_0123; imem_rvalid_i = 1'b1;
    #1;
    n_run++; if (imem_req_o !== 1'b0) begin n_fail++; $display("FAIL rst_req: got %b want 0", imem_req_o); end
    n_run++; if (fetch_valid_o !== 1'b0) begin n_fail++; $display("FAIL rst_fv: got %b want 0", fetch_valid_o); end
    n_run++; if (flush_o !== 1'b0) begin n_fail++; $display("FAIL rst_flush: got %b want 0", flush_o); end
    n_run++; if (pc_stall_o !== 1'b1) begin n_fail++; $display("FAIL rst_stall: got %b want 1", pc_stall_o); end
    n_run++; if (next_pc_o !== 32'd0) begin n_fail++; $display("FAIL rst_next_pc: got %h want 0", next_pc_o); end
    @(negedge clk_i);
    rst_ni = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      if (c == 3) begin br_req_i = 1'b0; imem_rvalid_i = 1'b0; end
      #1;
      n_run++; if (imem_req_o !== 1'b0) begin n_fail++; $display("FAIL hold_req c%0d: got %b want 0", c, imem_req_o); end
      n_run++; if (flush_o !== 1'b0) begin n_fail++; $display("FAIL hold_flush c%0d: got %b want 0", c, flush_o); end
      n_run++; if (pc_stall_o !== 1'b1) begin n_fail++; $display("FAIL hold_stall c%0d: got %b want 1", c, pc_stall_o); end
      n_run++; if (fetch_valid_o !== 1'b0) begin n_fail++; $display("FAIL hold_fv c%0d: got %b want 0", c, fetch_valid_o); end
      @(negedge clk_i);
    end
    #1;
    n_run++; if (imem_req_o !== 1'b1) begin n_fail++; $display("FAIL first_req: got %b want 1", imem_req_o); end
    n_run++; if (imem_addr_o !== 32'd0) begin n_fail++; $display("FAIL first_addr: got %h want 0", imem_addr_o); end
    $display("[TB] reset: first request seen in cycle 5");
  endtask

  task automatic test_normal();
    @(negedge clk_i); set_idle(); pc_i = 32'h100; imem_gnt_i = 1'b1; #1;
    n_run++; if (imem_req_o !== 1'b1) begin n_fail++; $display("FAIL norm_req: got %b want 1", imem_req_o); end
    n_run++; if (imem_addr_o !== 32'h100) begin n_fail++; $display("FAIL norm_addr: got %h want 00000100", imem_addr_o); end
    n_run++; if (pc_stall_o !== 1'b1) begin n_fail++; $display("FAIL norm_req_stall: got %b want 1", pc_stall_o); end
    @(negedge clk_i); imem_gnt_i = 1'b0; imem_rvalid_i = 1'b1; #1;
    n_run++; if (fetch_valid_o !== 1'b1) begin n_fail++; $display("FAIL norm_fv: got %b want 1", fetch_valid_o); end
    n_run++; if (next_pc_o !== 32'h104) begin n_fail++; $display("FAIL norm_next_pc: got %h want 00000104", next_pc_o); end
    n_run++; if (pc_stall_o !== 1'b0) begin n_fail++; $display("FAIL norm_stall: got %b want 0", pc_stall_o); end
    n_run++; if (flush_o !== 1'b0) begin n_fail++; $display("FAIL norm_flush: got %b want 0", flush_o); end
    n_run++; if (imem_req_o !== 1'b0) begin n_fail++; $display("FAIL norm_rsp_req: got %b want 0", imem_req_o); end
    @(negedge clk_i); imem_rvalid_i = 1'b0; pc_i = 32'h104; #1;
    n_run++; if (imem_req_o !== 1'b1) begin n_fail++; $display("FAIL norm_next_req: got %b want 1", imem_req_o); end
    n_run++; if (imem_addr_o !== 32'h104) begin n_fail++; $display("FAIL norm_next_addr: got %h want 00000104", imem_addr_o); end
    $display("[TB] normal fetch pc=00000100 -> next_pc=00000104");
  endtask

  task automatic test_dec_stall();
    @(negedge clk_i); set_idle(); pc_i = 32'h200; imem_gnt_i = 1'b1;
    @(negedge clk_i); imem_gnt_i = 1'b0; imem_rvalid_i = 1'b1; dec_stall_i = 1'b1; #1;
    n_run++; if (fetch_valid_o !== 1'b0) begin n_fail++; $display("FAIL dstall_fv: got %b want 0", fetch_valid_o); end
    n_run++; if (pc_stall_o !== 1'b1) begin n_fail++; $display("FAIL dstall_stall: got %b want 1", pc_stall_o); end
    @(negedge clk_i); imem_rvalid_i = 1'b0; dec_stall_i = 1'b0; #1;
    n_run++; if (imem_req_o !== 1'b1) begin n_fail++; $display("FAIL dstall_rereq: got %b want 1", imem_req_o); end
    n_run++; if (imem_addr_o !== 32'h200) begin n_fail++; $display("FAIL dstall_addr: got %h want 00000200", imem_addr_o); end
    $display("[TB] decode stall re-requests pc=00000200");
  endtask

  task automatic test_redirect_rsp();
    @(negedge clk_i); set_idle(); pc_i = 32'h300; imem_gnt_i = 1'b1;
    @(negedge clk_i); imem_gnt_i = 1'b0; br_req_i = 1'b1; br_pc_i = 32'h203; #1;
    n_run++; if (flush_o !== 1'b1) begin n_fail++; $display("FAIL brrsp_flush: got %b want 1", flush_o); end
    n_run++; if (next_pc_o !== 32'h200) begin n_fail++; $display("FAIL brrsp_next_pc: got %h want 00000200", next_pc_o); end
    n_run++; if (pc_stall_o !== 1'b0) begin n_fail++; $display("FAIL brrsp_stall: got %b want 0", pc_stall_o); end
    @(negedge clk_i); br_req_i = 1'b0; pc_i = 32'h200; #1;
    n_run++; if (flush_o !== 1'b0) begin n_fail++; $display("FAIL brrsp_flush_end: got %b want 0", flush_o); end
    n_run++; if (imem_req_o !== 1'b0) begin n_fail++; $display("FAIL brrsp_wait_req: got %b want 0", imem_req_o); end
    @(negedge clk_i); imem_rvalid_i = 1'b1; #1;
    n_run++; if (fetch_valid_o !== 1'b0) begin n_fail++; $display("FAIL brrsp_killed_fv: got %b want 0", fetch_valid_o); end
    n_run++; if (pc_stall_o !== 1'b1) begin n_fail++; $display("FAIL brrsp_killed_stall: got %b want 1", pc_stall_o); end
    @(negedge clk_i); imem_rvalid_i = 1'b0; #1;
    n_run++; if (imem_req_o !== 1'b1) begin n_fail++; $display("FAIL brrsp_req: got %b want 1", imem_req_o); end
    n_run++; if (imem_addr_o !== 32'h200) begin n_fail++; $display("FAIL brrsp_addr: got %h want 00000200", imem_addr_o); end
    $display("[TB] branch in RSP to 00000203 -> fetch 00000200, response killed");
  endtask

  task automatic test_redirect_req_gnt();
    @(negedge clk_i); set_idle(); pc_i = 32'h600; imem_gnt_i = 1'b1;
    br_req_i = 1'b1; br_pc_i = 32'h700; dec_stall_i = 1'b1; #1;
    n_run++; if (flush_o !== 1'b1) begin n_fail++; $display("FAIL brgnt_flush: got %b want 1", flush_o); end
    n_run++; if (next_pc_o !== 32'h700) begin n_fail++; $display("FAIL brgnt_next_pc: got %h want 00000700", next_pc_o); end
    n_run++; if (pc_stall_o !== 1'b0) begin n_fail++; $display("FAIL brgnt_stall: got %b want 0", pc_stall_o); end
    @(negedge clk_i); set_idle(); pc_i = 32'h700; imem_rvalid_i = 1'b1; #1;
    n_run++; if (fetch_valid_o !== 1'b0) begin n_fail++; $display("FAIL brgnt_killed_fv: got %b want 0", fetch_valid_o); end
    @(negedge clk_i); imem_rvalid_i = 1'b0; #1;
    n_run++; if (imem_addr_o !== 32'h700) begin n_fail++; $display("FAIL brgnt_addr: got %h want 00000700", imem_addr_o); end
    $display("[TB] branch with grant kills in-flight fetch");
  endtask

  task automatic test_redirect_rvalid();
    @(negedge clk_i); set_idle(); pc_i = 32'h800; imem_gnt_i = 1'b1;
    @(negedge clk_i); imem_gnt_i = 1'b0; imem_rvalid_i = 1'b1; br_req_i = 1'b1; br_pc_i = 32'h901; #1;
    n_run++; if (fetch_valid_o !== 1'b0) begin n_fail++; $display("FAIL brrv_fv: got %b want 0", fetch_valid_o); end
    n_run++; if (flush_o !== 1'b1) begin n_fail++; $display("FAIL brrv_flush: got %b want 1", flush_o); end
    n_run++; if (next_pc_o !== 32'h900) begin n_fail++; $display("FAIL brrv_next_pc: got %h want 00000900", next_pc_o); end
    @(negedge clk_i); set_idle(); pc_i = 32'h900; #1;
    n_run++; if (imem_req_o !== 1'b1) begin n_fail++; $display("FAIL brrv_req: got %b want 1", imem_req_o); end
    n_run++; if (imem_addr_o !== 32'h900) begin n_fail++; $display("FAIL brrv_addr: got %h want 00000900", imem_addr_o); end
    $display("[TB] branch coinciding with rvalid discards response");
  endtask

  task automatic test_trap_priority();
    logic [31:0] exp_pc;
`ifdef FETCH_CTRL_TRAP_EN
    exp_pc = 32'h8000_0010;
`else
    exp_pc = 32'h0000_0040;
`endif
    @(negedge clk_i); set_idle();
    trap_req_i = 1'b1; trap_pc_i = 32'h8000_0010; br_req_i = 1'b1; br_pc_i = 32'h40; #1;
    n_run++; if (next_pc_o !== exp_pc) begin n_fail++; $display("FAIL prio_next_pc: got %h want %h", next_pc_o, exp_pc); end
    n_run++; if (flush_o !== 1'b1) begin n_fail++; $display("FAIL prio_flush: got %b want 1", flush_o); end
    @(negedge clk_i); set_idle(); pc_i = exp_pc; trap_req_i = 1'b1; trap_pc_i = 32'h0000_0A02; #1;
    n_run++; if (imem_req_o !== 1'b1) begin n_fail++; $display("FAIL prio_stay_req: got %b want 1", imem_req_o); end
`ifdef FETCH_CTRL_TRAP_EN
    n_run++; if (flush_o !== 1'b1) begin n_fail++; $display("FAIL trap_only_flush: got %b want 1", flush_o); end
    n_run++; if (next_pc_o !== 32'h0000_0A00) begin n_fail++; $display("FAIL trap_only_next_pc: got %h want 00000a00", next_pc_o); end
`else
    n_run++; if (flush_o !== 1'b0) begin n_fail++; $display("FAIL trap_ignored_flush: got %b want 0", flush_o); end
    n_run++; if (pc_stall_o !== 1'b1) begin n_fail++; $display("FAIL trap_ignored_stall: got %b want 1", pc_stall_o); end
`endif
    @(negedge clk_i); set_idle();
    $display("[TB] trap+branch same cycle -> next_pc=%h", exp_pc);
  endtask

  task automatic test_wrap();
    @(negedge clk_i); set_idle(); pc_i = 32'hFFFF_FFFC; imem_gnt_i = 1'b1;
    @(negedge clk_i); imem_gnt_i = 1'b0; imem_rvalid_i = 1'b1; #1;
    n_run++; if (fetch_valid_o !== 1'b1) begin n_fail++; $display("FAIL wrap_fv: got %b want 1", fetch_valid_o); end
    n_run++; if (next_pc_o !== 32'd0) begin n_fail++; $display("FAIL wrap_next_pc: got %h want 00000000", next_pc_o); end
    @(negedge clk_i); set_idle(); pc_i = 32'd0;
    $display("[TB] pc=fffffffc wraps to 00000000");
  endtask

  task automatic test_reset_mid_rsp();
    @(negedge clk_i); set_idle(); pc_i = 32'hA00; imem_gnt_i = 1'b1;
    @(negedge clk_i); imem_gnt_i = 1'b0; br_req_i = 1'b1; br_pc_i = 32'hB00;
    @(negedge clk_i); br_req_i = 1'b0; rst_ni = 1'b0; #1;
    n_run++; if (pc_stall_o !== 1'b1) begin n_fail++; $display("FAIL mid_rst_stall: got %b want 1", pc_stall_o); end
    n_run++; if (next_pc_o !== 32'd0) begin n_fail++; $display("FAIL mid_rst_next_pc: got %h want 0", next_pc_o); end
    @(negedge clk_i); rst_ni = 1'b1;
    @(negedge clk_i); imem_rvalid_i = 1'b1; #1;
    n_run++; if (fetch_valid_o !== 1'b0) begin n_fail++; $display("FAIL stray_fv: got %b want 0", fetch_valid_o); end
    n_run++; if (imem_req_o !== 1'b0) begin n_fail++; $display("FAIL stray_req: got %b want 0", imem_req_o); end
    @(negedge clk_i); imem_rvalid_i = 1'b0; #1;
    n_run++; if (imem_req_o !== 1'b0) begin n_fail++; $display("FAIL stray_hold_c3: got %b want 0", imem_req_o); end
    @(negedge clk_i); #1;
    n_run++; if (imem_req_o !== 1'b0) begin n_fail++; $display("FAIL stray_hold_c4: got %b want 0", imem_req_o); end
    @(negedge clk_i); pc_i = 32'hC00; imem_gnt_i = 1'b1; #1;
    n_run++; if (imem_req_o !== 1'b1) begin n_fail++; $display("FAIL stray_req_c5: got %b want 1", imem_req_o); end
    @(negedge clk_i); imem_gnt_i = 1'b0; imem_rvalid_i = 1'b1; #1;
    n_run++; if (fetch_valid_o !== 1'b1) begin n_fail++; $display("FAIL kill_cleared_fv: got %b want 1", fetch_valid_o); end
    n_run++; if (next_pc_o !== 32'hC04) begin n_fail++; $display("FAIL kill_cleared_next_pc: got %h want 00000c04", next_pc_o); end
    @(negedge clk_i); set_idle();
    $display("[TB] reset during RSP: stray rvalid ignored, kill cleared");
  endtask

  initial begin
    test_reset();
    test_normal();
    test_dec_stall();
    test_redirect_rsp();
    test_redirect_req_gnt();
    test_redirect_rvalid();
    test_trap_priority();
    test_wrap();
    test_reset_mid_rsp();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
